// File: rtl/led_matrix_scan_driver.sv
// Row-scan driver for the 8x8 pong LED matrix: requests a row from the renderer,
// captures the returned bitmap, lights it for DWELL clocks, then blanks before the next row.
module led_matrix_scan_driver #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int BIT_OF_ROWS = 3,
  parameter int DWELL       = 1000,
  parameter int BLANK       = 4,
  parameter int COL_INV     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [15:0]            row_data,
  output logic [BIT_OF_ROWS-1:0] count,
  output logic [ROWS-1:0]        row_sel,
  output logic [COLS-1:0]        col_out,
  output logic                   frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_BLANK = 3'd4;

  localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

  localparam logic [CW-1:0]          DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]          BLANK_LAST = CW'(BLANK - 1);
  localparam logic [BIT_OF_ROWS-1:0] ROW_LAST   = BIT_OF_ROWS'(ROWS - 1);
  localparam logic [COLS-1:0]        BLANK_VAL  = (COL_INV != 0) ? '1 : '0;

  logic [2:0]    state;
  logic [CW-1:0] counter;

  // Columns and row select only change together on SHOW entry/exit, so a lit row never sees a column transition.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state      <= S_IDLE;
      counter    <= '0;
      count      <= '0;
      row_sel    <= '0;
      col_out    <= BLANK_VAL;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          count <= '0;
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          col_out <= (COL_INV != 0) ? ~row_data[COLS-1:0] : row_data[COLS-1:0];
          row_sel <= ROWS'(1) << count;
          counter <= '0;
          state   <= S_SHOW;
        end
        S_SHOW: begin
          if (counter == DWELL_LAST) begin
            row_sel <= '0;
            col_out <= BLANK_VAL;
            counter <= '0;
            state   <= S_BLANK;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        S_BLANK: begin
          if (counter == BLANK_LAST) begin
            state <= S_FETCH;
            if (count == ROW_LAST) begin
              count      <= '0;
              frame_done <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  if (COLS < 16) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^row_data[15:COLS];
  end

endmodule
